// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies the synchronised LOCK over a stable
// window, and releases a registered fabric reset. Lock-loss and timeout events are counted.
module pll_lock_supervisor #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             clr_stats,
  output logic             pll_rst,
  output logic             rst_out_n,
  output logic             ready,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PrstW = $clog2(PLL_RST_CYCLES + 1);

  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [PrstW-1:0] PrstLast = PrstW'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StQualify  = 3'd2,
    StRun      = 3'd3,
    StHold     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             lk_m_q, lk_s_q;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [PrstW-1:0] prst_q, prst_d;
  logic [CNT_W-1:0] loss_q, loss_d, tcnt_q, tcnt_d;
  logic             pll_rst_q, pll_rst_d, run_q, run_d;
  logic             loss_inc, tmo_inc;

  // State, timers, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StResetPll;
      lk_m_q    <= 1'b0;
      lk_s_q    <= 1'b0;
      tmo_q     <= '0;
      stab_q    <= '0;
      hold_q    <= '0;
      prst_q    <= '0;
      loss_q    <= '0;
      tcnt_q    <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lk_m_q    <= locked;
      lk_s_q    <= lk_m_q;
      tmo_q     <= tmo_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      prst_q    <= prst_d;
      loss_q    <= loss_d;
      tcnt_q    <= tcnt_d;
      pll_rst_q <= pll_rst_d;
      run_q     <= run_d;
    end
  end

  // Timers default to zero so each one starts cleared on entry to the state that uses it.
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    stab_d   = '0;
    hold_d   = '0;
    prst_d   = '0;
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
    case (state_q)
      StResetPll: begin
        if (prst_q >= PrstLast) begin
          state_d = StWaitLock;
        end else begin
          prst_d = prst_q + 1'b1;
        end
      end
      StWaitLock: begin
        tmo_d = tmo_q + 1'b1;
        if (lk_s_q) begin
          state_d = StQualify;
        end else if (tmo_q >= TmoLast) begin
          state_d = StResetPll;
          tmo_inc = 1'b1;
        end
      end
      StQualify: begin
        // The timeout window spans WAIT_LOCK and QUALIFY, so a flapping lock still expires.
        tmo_d  = tmo_q + 1'b1;
        stab_d = stab_q + 1'b1;
        if (tmo_q >= TmoLast) begin
          state_d = StResetPll;
          tmo_inc = 1'b1;
        end else if (!lk_s_q) begin
          state_d = StWaitLock;
        end else if (stab_q >= StabLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lk_s_q) begin
          state_d  = StHold;
          loss_inc = 1'b1;
        end
      end
      StHold: begin
        hold_d = hold_q + 1'b1;
        if (hold_q >= HoldLast) begin
          state_d = StResetPll;
        end
      end
      default: state_d = StResetPll;
    endcase
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_comb begin
    loss_d = loss_q;
    tcnt_d = tcnt_q;
    if (clr_stats) begin
      loss_d = '0;
      tcnt_d = '0;
    end else begin
      if (loss_inc && (loss_q != '1)) loss_d = loss_q + 1'b1;
      if (tmo_inc && (tcnt_q != '1)) tcnt_d = tcnt_q + 1'b1;
    end
  end

  // Outputs decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == StResetPll);
    run_d     = (state_d == StRun);
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out_n   = run_q;
  assign ready       = run_q;
  assign loss_cnt    = loss_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, corner-case sequences and a
// randomised run compared every cycle against a timestamp-based reference model.
module tb_pll_lock_supervisor;

  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int TMO    = 40;
  localparam int PRST   = 3;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic          clr_stats = 1'b0;
  logic          pll_rst, rst_out_n, ready;
  logic [CW-1:0] loss_cnt, timeout_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .PLL_RST_CYCLES(PRST),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (locked),
    .clr_stats  (clr_stats),
    .pll_rst    (pll_rst),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .loss_cnt   (loss_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: phases are tracked by the edge index at which they were entered.
  localparam int PRst = 0, PWait = 1, PQual = 2, PRun = 3, PHold = 4;
  int m_phase, now, t0, search_t0, qual_t0, m_loss, m_tmo;
  bit m_lkm, m_lks;

  task automatic model_reset();
    m_phase = PRst; now = 0; t0 = 0; search_t0 = 0; qual_t0 = 0;
    m_loss = 0; m_tmo = 0; m_lkm = 0; m_lks = 0;
  endtask

  task automatic model_step(input bit lk, input bit clr);
    int nxt;
    bit loss_ev, tmo_ev;
    nxt = m_phase; loss_ev = 0; tmo_ev = 0;
    now++;
    case (m_phase)
      PRst:  if (now - t0 >= PRST) begin nxt = PWait; search_t0 = now; end
      PWait: begin
        if (m_lks) begin nxt = PQual; qual_t0 = now; end
        else if (now - search_t0 >= TMO) begin nxt = PRst; tmo_ev = 1; end
      end
      PQual: begin
        if (now - search_t0 >= TMO) begin nxt = PRst; tmo_ev = 1; end
        else if (!m_lks) nxt = PWait;
        else if (now - qual_t0 >= STABLE) nxt = PRun;
      end
      PRun:  if (!m_lks) begin nxt = PHold; loss_ev = 1; end
      PHold: if (now - t0 >= HOLD) nxt = PRst;
      default: nxt = PRst;
    endcase
    if (nxt != m_phase) t0 = now;
    if (clr) begin
      m_loss = 0; m_tmo = 0;
    end else begin
      if (loss_ev && m_loss < CMAX) m_loss++;
      if (tmo_ev && m_tmo < CMAX) m_tmo++;
    end
    m_lks = m_lkm; m_lkm = lk; m_phase = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(locked, clr_stats);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    logic [6:0] act, exp;
    act = {pll_rst, rst_out_n, ready, loss_cnt, timeout_cnt};
    exp = {m_phase == PRst, m_phase == PRun, m_phase == PRun, 2'(m_loss), 2'(m_tmo)};
    chk(name, {25'd0, act}, {25'd0, exp});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; locked = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit lk;
    bit clr;
    int n;
    bit e_prst;
    bit e_run;
    int e_loss;
    int e_tmo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Power-up pulse, lock, RUN, lock loss, HOLD, re-reset.
    vecs[0] = '{0, 0, 2,  1, 0, 0, 0};
    vecs[1] = '{0, 0, 1,  0, 0, 0, 0};
    vecs[2] = '{1, 0, 10, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 1,  0, 1, 0, 0};
    vecs[4] = '{0, 0, 2,  0, 1, 0, 0};
    vecs[5] = '{0, 0, 1,  0, 0, 1, 0};
    vecs[6] = '{0, 0, 3,  0, 0, 1, 0};
    vecs[7] = '{0, 0, 1,  1, 0, 1, 0};
    vecs[8] = '{0, 0, 2,  1, 0, 1, 0};
    vecs[9] = '{0, 0, 1,  0, 0, 1, 0};

    do_reset();
    chk("reset_outputs", {27'd0, pll_rst, rst_out_n, ready, loss_cnt}, 32'h10);
    for (int i = 0; i < 10; i++) begin
      locked = vecs[i].lk;
      clr_stats = vecs[i].clr;
      repeat (vecs[i].n) tick();
      chk($sformatf("vec%0d", i),
          {24'd0, pll_rst, rst_out_n, ready, 1'b0, loss_cnt, timeout_cnt},
          {24'd0, vecs[i].e_prst, vecs[i].e_run, vecs[i].e_run, 1'b0,
           2'(vecs[i].e_loss), 2'(vecs[i].e_tmo)});
    end

    // Lock drops for 3 cycles inside QUALIFY; the window restarts from the restore.
    do_reset();
    repeat (3) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (10) tick();
    chk("flap_not_yet", {31'd0, rst_out_n}, 32'd0);
    tick();
    chk("flap_run", {30'd0, rst_out_n, ready}, 32'd3);
    chk("flap_counters", {28'd0, loss_cnt, timeout_cnt}, 32'd0);

    // Clear collides with a loss increment.
    do_reset();
    repeat (3) tick();
    locked = 1'b1;
    repeat (11) tick();
    chk("clr_run", {31'd0, rst_out_n}, 32'd1);
    locked = 1'b0;
    repeat (2) tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_wins", {28'd0, rst_out_n, 1'b0, loss_cnt}, 32'd0);

    // Repeated timeouts with lock absent; counter saturates at 3.
    do_reset();
    repeat (3) tick();
    for (int k = 1; k <= 4; k++) begin
      repeat ((k == 1) ? 39 : 42) tick();
      chk($sformatf("tmo%0d_pre", k), {31'd0, pll_rst}, 32'd0);
      tick();
      chk($sformatf("tmo%0d_pulse", k), {29'd0, pll_rst, timeout_cnt},
          {29'd0, 1'b1, 2'((k > 3) ? 3 : k)});
    end

    // Asynchronous reset in the middle of QUALIFY.
    locked = 1'b1;
    repeat (6) tick();
    chk("qual_state", {29'd0, pll_rst, timeout_cnt}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {26'd0, pll_rst, rst_out_n, ready, 1'b0, timeout_cnt}, 32'h20);

    // Randomised lock activity and occasional clears against the reference model.
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      locked = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        clr_stats = ($urandom_range(0, 31) == 0);
        tick();
        chk_model("random");
      end
    end
    clr_stats = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
